// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types for the pipeline stall/valid controller: drain FSM states
// and a stage-index type wide enough for any supported pipeline depth.
package lc3b_types;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    IDLE
  } drain_state_t;

  localparam int MAX_STAGES = 16;

  typedef logic [$clog2(MAX_STAGES)-1:0] stage_idx_t;

endpackage

// File: rtl/pipe_stall_ctrl_stall_counter.sv
// Saturating per-stage stall-cycle counter; clear wins over increment.
module stall_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      cnt <= '0;
    end else if (inc && !(&cnt)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall and valid controller: owns every stage's valid bit, derives
// load enables from stall requests, squashes on redirect and handles drain.
module pipe_stall_ctrl
  import lc3b_types::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int CNT_W      = 16,
  parameter int COLLAPSE   = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          fetch_valid,
  input  logic [NUM_STAGES-1:0]         stall_req,
  input  logic                          flush,
  input  logic [$clog2(NUM_STAGES)-1:0] flush_stage,
  input  logic                          drain_req,
  input  logic                          cnt_clear,
  output logic [NUM_STAGES-1:0]         load,
  output logic [NUM_STAGES-1:0]         stage_valid,
  output logic                          fetch_ready,
  output logic                          drained,
  output logic [NUM_STAGES*CNT_W-1:0]   stall_cnt
);

  localparam logic COLLAPSE_EN = (COLLAPSE != 0);

  logic [NUM_STAGES-1:0] hold;
  logic [NUM_STAGES-1:0] next_valid;
  drain_state_t          state;

  // Backpressure ripples from the oldest stage towards fetch; a bubble
  // absorbs it when collapsing is enabled.
  always_comb begin
    hold = '0;
    hold[NUM_STAGES-1] = stall_req[NUM_STAGES-1];
    for (int i = NUM_STAGES-2; i >= 0; i--) begin
      hold[i] = stall_req[i] | (hold[i+1] & (stage_valid[i+1] | ~COLLAPSE_EN));
    end
  end

  // An empty stage still captures under collapsing, so the instruction its
  // upstream neighbour releases into the bubble is never dropped.
  assign load        = ~hold | ({NUM_STAGES{COLLAPSE_EN}} & ~stage_valid);
  assign fetch_ready = ~hold[0] & (state == RUN);

  for (genvar j = 0; j < NUM_STAGES; j++) begin : g_valid
    localparam stage_idx_t IDX = stage_idx_t'(j);
    logic incoming;
    logic nv;

    if (j == 0) begin : g_head
      assign incoming = fetch_valid & fetch_ready;
    end else begin : g_body
      assign incoming = stage_valid[j-1] & ~hold[j-1];
    end

    // Younger-than-redirect work dies; the resolving stage keeps its own
    // instruction but refuses whatever would flow into it.
    always_comb begin
      nv = load[j] ? incoming : stage_valid[j];
      if (flush) begin
        if (IDX < stage_idx_t'(flush_stage)) begin
          nv = 1'b0;
        end else if ((IDX == stage_idx_t'(flush_stage)) && load[j]) begin
          nv = 1'b0;
        end
      end
    end

    assign next_valid[j] = nv;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stage_valid <= '0;
    end else begin
      stage_valid <= next_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= RUN;
      drained <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (drain_req) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (~|stage_valid) begin
            state   <= IDLE;
            drained <= 1'b1;
          end else if (!drain_req) begin
            state <= RUN;
          end
        end
        IDLE: begin
          if (!drain_req) begin
            state   <= RUN;
            drained <= 1'b0;
          end
        end
        default: begin
          state   <= RUN;
          drained <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_cnt
    stall_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk    (clk),
      .reset_n(reset_n),
      .clear  (cnt_clear),
      .inc    (stage_valid[i] & hold[i]),
      .cnt    (stall_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: one collapsing and one non-collapsing
// instance driven in lockstep with hand-computed expectations.
module tb_pipe_stall_ctrl;

  localparam int NS = 5;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          fetch_valid;
  logic [NS-1:0] stall_req;
  logic          flush;
  logic [2:0]    flush_stage;
  logic          drain_req;
  logic          cnt_clear;

  logic [NS-1:0]    load_c, valid_c, load_n, valid_n;
  logic             ready_c, ready_n, drained_c, drained_n;
  logic [NS*CW-1:0] cnt_c, cnt_n;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.NUM_STAGES(NS), .CNT_W(CW), .COLLAPSE(1)) dut (
    .clk(clk), .reset_n(reset_n), .fetch_valid(fetch_valid),
    .stall_req(stall_req), .flush(flush), .flush_stage(flush_stage),
    .drain_req(drain_req), .cnt_clear(cnt_clear), .load(load_c),
    .stage_valid(valid_c), .fetch_ready(ready_c), .drained(drained_c),
    .stall_cnt(cnt_c)
  );

  pipe_stall_ctrl #(.NUM_STAGES(NS), .CNT_W(CW), .COLLAPSE(0)) dut_nc (
    .clk(clk), .reset_n(reset_n), .fetch_valid(fetch_valid),
    .stall_req(stall_req), .flush(flush), .flush_stage(flush_stage),
    .drain_req(drain_req), .cnt_clear(cnt_clear), .load(load_n),
    .stage_valid(valid_n), .fetch_ready(ready_n), .drained(drained_n),
    .stall_cnt(cnt_n)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; fetch_valid = 1'b0; stall_req = '0; flush = 1'b0;
    flush_stage = '0; drain_req = 1'b0; cnt_clear = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic fill();
    fetch_valid = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b1; fetch_valid = 1'b1; stall_req = 5'b01000; flush = 1'b0;
    flush_stage = '0; drain_req = 1'b0; cnt_clear = 1'b0;
    repeat (3) tick();
    reset_n = 1'b0; drain_req = 1'b1;
    tick();
    drain_req = 1'b0; fetch_valid = 1'b0; stall_req = '0;
    tick();
    total++; if (valid_c !== 5'b00000) begin bad++; $display("[TB] FAIL reset_valid: got %b expected %b", valid_c, 5'b00000); end
    total++; if (valid_n !== 5'b00000) begin bad++; $display("[TB] FAIL reset_valid_nc: got %b expected %b", valid_n, 5'b00000); end
    total++; if (drained_c !== 1'b0 || drained_n !== 1'b0) begin bad++; $display("[TB] FAIL reset_drained: got %b/%b expected 0/0", drained_c, drained_n); end
    total++; if (cnt_c !== '0 || cnt_n !== '0) begin bad++; $display("[TB] FAIL reset_cnt: got %h/%h expected 0", cnt_c, cnt_n); end
    total++; if (ready_c !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %b expected 1", ready_c); end
    total++; if (load_c !== 5'b11111) begin bad++; $display("[TB] FAIL reset_load: got %b expected %b", load_c, 5'b11111); end
    reset_n = 1'b1;
  endtask

  task automatic test_fill();
    logic [NS-1:0] exp;
    do_reset();
    fetch_valid = 1'b1;
    for (int i = 0; i < NS; i++) begin
      #1;
      total++; if (load_c !== 5'b11111) begin bad++; $display("[TB] FAIL fill_load%0d: got %b expected %b", i, load_c, 5'b11111); end
      tick();
      exp = 5'b11111 >> (4 - i);
      total++; if (valid_c !== exp) begin bad++; $display("[TB] FAIL fill_valid%0d: got %b expected %b", i, valid_c, exp); end
    end
  endtask

  task automatic test_stall_collapse();
    stall_req = 5'b01000;
    fetch_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (load_c !== 5'b10000) begin bad++; $display("[TB] FAIL stall_load%0d: got %b expected %b", c, load_c, 5'b10000); end
      total++; if (ready_c !== 1'b0) begin bad++; $display("[TB] FAIL stall_ready%0d: got %b expected 0", c, ready_c); end
      tick();
    end
    total++; if (valid_c !== 5'b01111) begin bad++; $display("[TB] FAIL stall_valid: got %b expected %b", valid_c, 5'b01111); end
    total++; if (cnt_c[3*CW +: CW] !== 16'd3) begin bad++; $display("[TB] FAIL stall_cnt3: got %0d expected 3", cnt_c[3*CW +: CW]); end
    total++; if (cnt_c[4*CW +: CW] !== 16'd0) begin bad++; $display("[TB] FAIL stall_cnt4: got %0d expected 0", cnt_c[4*CW +: CW]); end
    stall_req = '0;
  endtask

  task automatic test_collapse();
    logic [4:0] pattern;
    do_reset();
    pattern = 5'b10101;
    for (int i = 0; i < NS; i++) begin
      fetch_valid = pattern[i];
      tick();
    end
    total++; if (valid_c !== 5'b10101 || valid_n !== 5'b10101) begin bad++; $display("[TB] FAIL bubble_setup: got %b/%b expected 10101", valid_c, valid_n); end
    stall_req = 5'b10000; fetch_valid = 1'b0;
    #1;
    total++; if (load_c !== 5'b01111) begin bad++; $display("[TB] FAIL collapse_load: got %b expected %b", load_c, 5'b01111); end
    total++; if (load_n !== 5'b00000) begin bad++; $display("[TB] FAIL nocollapse_load: got %b expected %b", load_n, 5'b00000); end
    total++; if (ready_c !== 1'b1 || ready_n !== 1'b0) begin bad++; $display("[TB] FAIL collapse_ready: got %b/%b expected 1/0", ready_c, ready_n); end
    tick();
    total++; if (valid_c !== 5'b11010) begin bad++; $display("[TB] FAIL collapse_valid: got %b expected %b", valid_c, 5'b11010); end
    total++; if (valid_n !== 5'b10101) begin bad++; $display("[TB] FAIL nocollapse_valid: got %b expected %b", valid_n, 5'b10101); end
    stall_req = '0;
  endtask

  task automatic test_flush();
    do_reset();
    fill();
    flush = 1'b1; flush_stage = 3'd2;
    tick();
    total++; if (valid_c !== 5'b11000) begin bad++; $display("[TB] FAIL flush_k2: got %b expected %b", valid_c, 5'b11000); end
    flush_stage = 3'd0;
    tick();
    total++; if (valid_c !== 5'b10000) begin bad++; $display("[TB] FAIL flush_k0: got %b expected %b", valid_c, 5'b10000); end
    flush = 1'b0;
    fill();
    stall_req = 5'b00100; flush = 1'b1; flush_stage = 3'd3;
    tick();
    total++; if (valid_c !== 5'b10000) begin bad++; $display("[TB] FAIL flush_held_young: got %b expected %b", valid_c, 5'b10000); end
    stall_req = '0; flush = 1'b0;
    fill();
    stall_req = 5'b00100; flush = 1'b1; flush_stage = 3'd2;
    tick();
    total++; if (valid_c !== 5'b10100) begin bad++; $display("[TB] FAIL flush_held_k: got %b expected %b", valid_c, 5'b10100); end
    stall_req = '0; flush = 1'b0;
  endtask

  task automatic test_drain();
    do_reset();
    fill();
    drain_req = 1'b1; fetch_valid = 1'b0;
    tick();
    fetch_valid = 1'b1;
    #1;
    total++; if (ready_c !== 1'b0) begin bad++; $display("[TB] FAIL drain_ready: got %b expected 0", ready_c); end
    repeat (4) tick();
    total++; if (valid_c !== 5'b00000) begin bad++; $display("[TB] FAIL drain_empty: got %b expected %b", valid_c, 5'b00000); end
    total++; if (drained_c !== 1'b0) begin bad++; $display("[TB] FAIL drain_early: got %b expected 0", drained_c); end
    tick();
    total++; if (drained_c !== 1'b1) begin bad++; $display("[TB] FAIL drain_done: got %b expected 1", drained_c); end
    drain_req = 1'b0;
    #1;
    total++; if (ready_c !== 1'b0) begin bad++; $display("[TB] FAIL idle_ready: got %b expected 0", ready_c); end
    tick();
    total++; if (drained_c !== 1'b0) begin bad++; $display("[TB] FAIL resume_drained: got %b expected 0", drained_c); end
    total++; if (ready_c !== 1'b1) begin bad++; $display("[TB] FAIL resume_ready: got %b expected 1", ready_c); end
    total++; if (valid_c !== 5'b00000) begin bad++; $display("[TB] FAIL idle_fetch: got %b expected %b", valid_c, 5'b00000); end
    fetch_valid = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    fill();
    stall_req = 5'b10000; fetch_valid = 1'b0; cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    total++; if (cnt_c[4*CW +: CW] !== 16'h0000) begin bad++; $display("[TB] FAIL clear_first: got %h expected 0000", cnt_c[4*CW +: CW]); end
    repeat (65534) tick();
    total++; if (cnt_c[4*CW +: CW] !== 16'hFFFE) begin bad++; $display("[TB] FAIL cnt_fffe: got %h expected fffe", cnt_c[4*CW +: CW]); end
    tick();
    total++; if (cnt_c[4*CW +: CW] !== 16'hFFFF) begin bad++; $display("[TB] FAIL cnt_ffff: got %h expected ffff", cnt_c[4*CW +: CW]); end
    tick();
    total++; if (cnt_c[4*CW +: CW] !== 16'hFFFF) begin bad++; $display("[TB] FAIL cnt_sat: got %h expected ffff", cnt_c[4*CW +: CW]); end
    cnt_clear = 1'b1;
    tick();
    total++; if (cnt_c[4*CW +: CW] !== 16'h0000) begin bad++; $display("[TB] FAIL cnt_clear_stall: got %h expected 0000", cnt_c[4*CW +: CW]); end
    cnt_clear = 1'b0; stall_req = '0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stall_collapse();
    test_collapse();
    test_flush();
    test_drain();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
